frame_uart_tx: RTL and testbench

- Reads the 320x240 12-bit frame buffer sequentially through the BRAM read port and streams every pixel out over UART as two safety-framed bytes.
- Uses the same byte format the UART receive path expects, so a dumped frame can be looped back or captured on the host.
- Runs in the UART clock domain and owns a second read port (or time-shared port) of the frame buffer.

---
 rtl/frame_uart_tx.sv | 151 +++++++++++++++
 tb/tb_frame_uart_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/frame_uart_tx.sv
// Streams a whole frame buffer out over an 8N1 UART, one pixel as two framed bytes
// (LO then HI), each byte followed by GAP_BITS idle bit-times.
module frame_uart_tx #(
   parameter int PIXELS       = 76800,
   parameter int CLKS_PER_BIT = 14,
   parameter int GAP_BITS     = 2,
   parameter int BRAM_LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [17:0] bram_addr,
   input  logic [11:0] bram_data,
   output logic        tx,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP, GAP} state_t;

   localparam logic [15:0] CPB_LAST   = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] FETCH_LAST = 16'(BRAM_LATENCY);
   localparam logic [15:0] GAP_LAST   = 16'(GAP_BITS - 1);
   localparam logic [17:0] LAST_ADDR  = 18'(PIXELS - 1);

   state_t      state_q;
   logic [15:0] cnt_q;
   logic [15:0] bit_q;
   logic [11:0] pix_q;
   logic        hi_q;
   logic [17:0] addr_q;
   logic        tx_q;
   logic        busy_q;
   logic        done_q;

   logic [7:0]  cur_byte;
   logic        last_tick;
   logic        byte_end;

   // Each byte carries six payload bits with a forced 0 at both ends.
   assign cur_byte  = hi_q ? {1'b0, pix_q[11:6], 1'b0} : {1'b0, pix_q[5:0], 1'b0};
   assign last_tick = (cnt_q == CPB_LAST);
   assign byte_end  = last_tick &&
                      (((state_q == STOP) && (GAP_BITS == 0)) ||
                       ((state_q == GAP) && (bit_q == GAP_LAST)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         pix_q   <= '0;
         hi_q    <= 1'b0;
         addr_q  <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // A start coinciding with the done pulse is deliberately dropped.
               if (start && !done_q) begin
                  busy_q  <= 1'b1;
                  addr_q  <= '0;
                  cnt_q   <= '0;
                  state_q <= FETCH;
               end
            end
            FETCH: begin
               if (cnt_q == FETCH_LAST) begin
                  pix_q   <= bram_data;
                  hi_q    <= 1'b0;
                  cnt_q   <= '0;
                  tx_q    <= 1'b0;
                  state_q <= START;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            START: begin
               if (last_tick) begin
                  cnt_q   <= '0;
                  bit_q   <= '0;
                  tx_q    <= cur_byte[0];
                  state_q <= DATA;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            DATA: begin
               if (last_tick) begin
                  cnt_q <= '0;
                  if (bit_q == 16'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= STOP;
                  end else begin
                     bit_q <= bit_q + 16'd1;
                     tx_q  <= cur_byte[bit_q[2:0] + 3'd1];
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            STOP: begin
               if (last_tick) begin
                  cnt_q   <= '0;
                  bit_q   <= '0;
                  state_q <= GAP;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            GAP: begin
               if (last_tick) begin
                  cnt_q <= '0;
                  bit_q <= bit_q + 16'd1;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            default: state_q <= IDLE;
         endcase

         // End of a byte's trailing idle time overrides the per-state updates above.
         if (byte_end) begin
            cnt_q <= '0;
            bit_q <= '0;
            if (!hi_q) begin
               hi_q    <= 1'b1;
               tx_q    <= 1'b0;
               state_q <= START;
            end else if (addr_q == LAST_ADDR) begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               addr_q  <= '0;
               state_q <= IDLE;
            end else begin
               addr_q  <= addr_q + 18'd1;
               state_q <= FETCH;
            end
         end
      end
   end

   assign bram_addr = addr_q;
   assign tx        = tx_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_frame_uart_tx.sv
// Directed and randomized frames through frame_uart_tx, decoded from the serial
// line and compared against a pixel-to-byte reference model.
module tb_frame_uart_tx;

   localparam int PIXELS = 4;
   localparam int C      = 4;
   localparam int G      = 2;
   localparam int L      = 2;
   localparam int FRAME_CYCLES = PIXELS * (L + 1 + 2 * (10 + G) * C);

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [17:0] bram_addr;
   logic [11:0] bram_data;
   logic        tx;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   frame_uart_tx #(
      .PIXELS(PIXELS), .CLKS_PER_BIT(C), .GAP_BITS(G), .BRAM_LATENCY(L)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .bram_addr(bram_addr),
      .bram_data(bram_data), .tx(tx), .busy(busy), .done(done)
   );

   // Frame buffer with a two-stage read pipeline; out-of-range reads return junk.
   logic [11:0] mem [PIXELS];
   logic [11:0] d1, d2;
   always @(posedge clk) begin
      d1 <= (bram_addr < 18'(PIXELS)) ? mem[bram_addr[1:0]] : 12'hEEE;
      d2 <= d1;
   end
   assign bram_data = d2;

   int compared   = 0;
   int mismatched = 0;
   byte unsigned rx_q[$];
   byte unsigned exp_q[$];
   logic [17:0]  addr_log[$];
   logic [17:0]  prev_addr = '0;
   int           glitch_cnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
      $display("check %-22s got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (reset !== 1'b0) prev_addr = '0;
      else if (bram_addr !== prev_addr) begin
         addr_log.push_back(bram_addr);
         prev_addr = bram_addr;
      end
   end

   // Serial decoder: every bit must hold for exactly C cycles, stop and gap high.
   always begin : rx_mon
      logic [7:0] b;
      bit ok, aborted;
      logic lvl;
      @(negedge clk);
      if (reset === 1'b0 && tx === 1'b0) begin
         ok = 1; aborted = 0; b = '0; lvl = 1'b0;
         for (int k = 0; k < (10 + G) * C; k++) begin
            if (k > 0) @(negedge clk);
            if (reset !== 1'b0) begin aborted = 1; break; end
            if (k / C == 0) lvl = 1'b0;
            else if (k / C >= 9) lvl = 1'b1;
            else if (k % C == 0) begin lvl = tx; b[k / C - 1] = tx; end
            if (tx !== lvl) ok = 0;
         end
         if (!aborted) begin
            rx_q.push_back(b);
            if (!ok) glitch_cnt++;
         end
      end
   end

   task automatic build_expected();
      exp_q.delete();
      for (int i = 0; i < PIXELS; i++) begin
         exp_q.push_back(byte'((int'(mem[i]) % 64) * 2));
         exp_q.push_back(byte'((int'(mem[i]) / 64) * 2));
      end
   endtask

   task automatic run_frame(input bit spam, input bit start_on_done);
      int busy_cyc, done_cyc, extra;
      bit seen_done;
      build_expected();
      rx_q.delete();
      addr_log.delete();
      glitch_cnt = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      busy_cyc = 0; done_cyc = 0; seen_done = 0;
      for (int n = 0; n < FRAME_CYCLES + 50 && !seen_done; n++) begin
         if (busy === 1'b1) busy_cyc++;
         if (done === 1'b1) begin
            done_cyc++;
            seen_done = 1;
            check("busy_low_at_done", 32'(busy), 32'd0);
            if (start_on_done) start = 1'b1;
         end else if (spam && busy === 1'b1 && n % 9 == 3) begin
            start = 1'b1;
         end
         @(negedge clk);
         start = 1'b0;
      end
      check("done_seen", 32'(seen_done), 32'd1);
      extra = 0;
      for (int n = 0; n < 40; n++) begin
         if (busy !== 1'b0 || done !== 1'b0 || tx !== 1'b1) extra++;
         @(negedge clk);
      end
      check("quiet_after_done", 32'(extra), 32'd0);
      check("busy_cycles", 32'(busy_cyc), 32'(FRAME_CYCLES));
      check("done_pulses", 32'(done_cyc), 32'd1);
      check("byte_count", 32'(rx_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("byte[%0d]", i), (i < rx_q.size()) ? 32'(rx_q[i]) : 32'h100, 32'(exp_q[i]));
      check("addr_changes", 32'(addr_log.size()), 32'(PIXELS));
      for (int i = 0; i < PIXELS; i++)
         check($sformatf("addr_seq[%0d]", i),
               (i < addr_log.size()) ? 32'(addr_log[i]) : 32'hFFFFF, 32'((i + 1) % PIXELS));
      check("bit_timing", 32'(glitch_cnt), 32'd0);
   endtask

   initial begin
      int quiet, n;
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_tx", 32'(tx), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_addr", 32'(bram_addr), 32'd0);
      reset = 1'b0;
      quiet = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) quiet++;
      end
      check("idle_no_activity", 32'(quiet), 32'd0);

      mem[0] = 12'hFFF; mem[1] = 12'h000; mem[2] = 12'h3F0; mem[3] = 12'h00F;
      run_frame(0, 0);
      run_frame(1, 1);

      mem[0] = 12'hABC;
      for (int i = 1; i < PIXELS; i++) mem[i] = 12'($urandom);
      run_frame(0, 0);
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < PIXELS; i++) mem[i] = 12'($urandom);
         run_frame(f[0], 0);
      end

      // Abort a frame during the start bit of its third byte.
      for (int i = 0; i < PIXELS; i++) mem[i] = 12'($urandom);
      rx_q.delete();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      n = 0;
      while (rx_q.size() < 2 && n < 2000) begin @(negedge clk); n++; end
      while (tx !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
      check("reach_third_byte", 32'(n < 2000), 32'd1);
      repeat (2) @(negedge clk);
      check("tx_low_before_reset", 32'(tx), 32'd0);
      reset = 1'b1;
      #1;
      check("abort_tx", 32'(tx), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_addr", 32'(bram_addr), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      quiet = 0;
      repeat (30) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) quiet++;
      end
      check("idle_after_abort", 32'(quiet), 32'd0);
      check("bytes_before_abort", 32'(rx_q.size()), 32'd2);
      for (int i = 0; i < PIXELS; i++) mem[i] = 12'($urandom);
      run_frame(0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
